instr_sequencer: RTL

- Program sequencer for the 8-bit register/ALU datapath. It holds a small instruction store, loaded by a host, and replays it into the datapath's 21-bit instruction port with a one-cycle load strobe per instruction.
- Sits between the host/test harness and the datapath. It owns the datapath's `instruction` and `ld` inputs, and the datapath's 8-bit result is fed back for capture.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/instr_sequencer_if.sv | 40 ++++
 rtl/instr_store.sv | 25 ++
 rtl/instr_sequencer.sv | 116 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit datapath instruction format and the sequencer FSM.
package cpu_pkg;
    localparam int IW = 21;

    localparam int Z_BIT    = 20;
    localparam int OP_MSB   = 19;
    localparam int OP_LSB   = 17;
    localparam int IMM_MSB  = 16;
    localparam int IMM_LSB  = 9;
    localparam int SRC1_MSB = 8;
    localparam int SRC1_LSB = 6;
    localparam int SRC2_MSB = 5;
    localparam int SRC2_LSB = 3;
    localparam int DST_MSB  = 2;
    localparam int DST_LSB  = 0;

    localparam logic [IW-1:0] HALT_WORD = 21'h1FFFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DONE
    } seq_state_t;
endpackage

// File: rtl/instr_sequencer_if.sv
// Host/datapath-facing bundle of instr_sequencer. INSTR_SEQUENCER_SINGLE_STEP_EN adds step and step_mode.
interface instr_sequencer_if #(
    parameter int AW = 4,
    parameter int IW = cpu_pkg::IW
) ();
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [IW-1:0] prog_data;
    logic          start;
    logic [AW:0]   len;
    logic [7:0]    dp_result;
    logic [IW-1:0] instr_out;
    logic          ld_out;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic [7:0]    last_result;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    logic          step;
    logic          step_mode;

    modport master (
        output prog_we, prog_addr, prog_data, start, len, dp_result, step, step_mode,
        input  instr_out, ld_out, pc, busy, done, last_result
    );
    modport slave (
        input  prog_we, prog_addr, prog_data, start, len, dp_result, step, step_mode,
        output instr_out, ld_out, pc, busy, done, last_result
    );
`else
    modport master (
        output prog_we, prog_addr, prog_data, start, len, dp_result,
        input  instr_out, ld_out, pc, busy, done, last_result
    );
    modport slave (
        input  prog_we, prog_addr, prog_data, start, len, dp_result,
        output instr_out, ld_out, pc, busy, done, last_result
    );
`endif
endinterface

// File: rtl/instr_store.sv
// Instruction store: synchronous write, registered read with write-first bypass on address match.
module instr_store #(
    parameter int AW = 4,
    parameter int IW = 21
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);
    logic [IW-1:0] mem_q [2**AW];
    logic [IW-1:0] rdata_q;

    // Bypass lets a start issued together with a write fetch the new word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= (we && (waddr == raddr)) ? wdata : mem_q[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/instr_sequencer.sv
// Replays the instruction store into the datapath, one ld_out strobe per instruction.
// INSTR_SEQUENCER_SINGLE_STEP_EN: FETCH holds until a step pulse while step_mode is set.
//
// state   | meaning
// IDLE    | waiting for start; store writable
// FETCH   | store word for pc available; halt check, latch into instr_out
// ISSUE   | ld_out high; advance pc and issue counter or finish
// DONE    | done pulse; capture dp_result into last_result
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int            AW        = 4,
    parameter int            IW        = cpu_pkg::IW,
    parameter logic [IW-1:0] HALT_WORD = cpu_pkg::HALT_WORD
) (
    input logic               clk,
    input logic               rst,
    instr_sequencer_if.slave  bus
);
    seq_state_t    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW:0]   len_q, len_d;
    logic [IW-1:0] instr_q, instr_d;
    logic [7:0]    res_q, res_d;
    logic [IW-1:0] rd_word;
    logic          busy_w;
    logic          advance;

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    assign advance = !bus.step_mode || bus.step;
`else
    assign advance = 1'b1;
`endif

    assign busy_w = (state_q == S_FETCH) || (state_q == S_ISSUE);

    // Read address follows pc_d so the word is ready on entry to FETCH.
    instr_store #(.AW(AW), .IW(IW)) u_store (
        .clk   (clk),
        .we    (bus.prog_we && !busy_w),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (pc_d),
        .rdata (rd_word)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        instr_d = instr_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pc_d    = '0;
                    cnt_d   = '0;
                    len_d   = bus.len;
                    state_d = (bus.len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (advance) begin
                    if (rd_word == HALT_WORD) begin
                        state_d = S_DONE;
                    end else begin
                        instr_d = rd_word;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // Termination uses the issue counter so programs longer than the store wrap pc.
                if (cnt_q == len_q - (AW+1)'(1)) begin
                    state_d = S_DONE;
                end else begin
                    pc_d    = pc_q + AW'(1);
                    cnt_d   = cnt_q + (AW+1)'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                res_d   = bus.dp_result;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            instr_q <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            instr_q <= instr_d;
            res_q   <= res_d;
        end
    end

    assign bus.instr_out   = instr_q;
    assign bus.ld_out      = (state_q == S_ISSUE);
    assign bus.pc          = pc_q;
    assign bus.busy        = busy_w;
    assign bus.done        = (state_q == S_DONE);
    assign bus.last_result = res_q;
endmodule
